// File: rtl/rd_data_fifo_sc.sv
// Single-clock read-data FIFO between the DDR2 read-capture path and the user read port.
// Status flags are registered from the next occupancy so they always agree with data_cnt.
module rd_data_fifo_sc #(
   parameter  int DATA_WIDTH = 128,
   parameter  int DEPTH      = 16,
   parameter  int AF_THRESH  = 12,
   parameter  int AE_THRESH  = 2,
   parameter  int BURST_LEN  = 8,
   parameter  int AUTO_DRAIN = 0,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  din_vd,
   input  logic                  rd_en,
   input  logic                  err_clr,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_vd,
   output logic                  full,
   output logic                  almost_full,
   output logic                  empty,
   output logic                  almost_empty,
   output logic                  burst_rdy,
   output logic [AW:0]           data_cnt,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [AW:0] CNT_FULL  = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_AF    = (AW+1)'(AF_THRESH);
   localparam logic [AW:0] CNT_AE    = (AW+1)'(AE_THRESH);
   localparam logic [AW:0] CNT_BURST = (AW+1)'(BURST_LEN);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  rd_req;
   logic                  wr_acc;
   logic                  rd_acc;
   logic [AW:0]           cnt_next;
   logic                  overflow_set;
   logic                  underflow_set;

   // Accept decisions use only the pre-edge flags: no fall-through, no write-into-freed-slot.
   always_comb begin
      rd_req        = (AUTO_DRAIN != 0) ? !empty : rd_en;
      wr_acc        = din_vd & !full;
      rd_acc        = rd_req & !empty;
      cnt_next      = data_cnt + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
      overflow_set  = din_vd & full;
      underflow_set = (AUTO_DRAIN == 0) & rd_en & empty;
   end

   always_ff @(posedge clk) begin
      if (wr_acc && !reset) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         data_cnt     <= '0;
         dout         <= '0;
         dout_vd      <= 1'b0;
         full         <= 1'b0;
         almost_full  <= 1'b0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         burst_rdy    <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + AW'(1);
            dout   <= mem[rd_ptr];
         end
         dout_vd      <= rd_acc;
         data_cnt     <= cnt_next;
         full         <= (cnt_next == CNT_FULL);
         almost_full  <= (cnt_next >= CNT_AF);
         empty        <= (cnt_next == '0);
         almost_empty <= (cnt_next <= CNT_AE);
         burst_rdy    <= (cnt_next >= CNT_BURST);
      end
   end

   // A new error in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (overflow_set) begin
            overflow <= 1'b1;
         end else if (err_clr) begin
            overflow <= 1'b0;
         end
         if (underflow_set) begin
            underflow <= 1'b1;
         end else if (err_clr) begin
            underflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rd_data_fifo_sc.sv
// Bench for rd_data_fifo_sc: one instance per read mode, a queue-based reference model,
// a directed vector table and hand-written multi-cycle sequences, then random traffic.
module tb_rd_data_fifo_sc;

   typedef logic [127:0] wq_t [$];

   typedef struct {
      bit           rst;
      bit           wr;
      bit           rd;
      bit           clr;
      logic [127:0] din;
      int           cnt;
      bit           vd;
      logic [127:0] dout;
      bit           ov;
      bit           un;
   } vec_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;

   logic [127:0] din0 = '0, din1 = '0;
   logic         din_vd0 = 1'b0, din_vd1 = 1'b0;
   logic         rd_en0 = 1'b0, rd_en1 = 1'b0;
   logic         err_clr0 = 1'b0, err_clr1 = 1'b0;

   logic [127:0] dout0, dout1;
   logic         dout_vd0, dout_vd1;
   logic         full0, full1, almost_full0, almost_full1;
   logic         empty0, empty1, almost_empty0, almost_empty1;
   logic         burst_rdy0, burst_rdy1;
   logic [4:0]   data_cnt0, data_cnt1;
   logic         overflow0, overflow1, underflow0, underflow1;

   int           errors = 0;
   int           checks = 0;

   wq_t          q0;
   wq_t          q1;
   logic [127:0] m_dout [2];
   bit           m_vd [2];
   bit           m_ov [2];
   bit           m_un [2];

   vec_t         vecs [$];

   rd_data_fifo_sc #(
      .DATA_WIDTH(128), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .BURST_LEN(8), .AUTO_DRAIN(0)
   ) dut0 (
      .clk(clk), .reset(reset), .din(din0), .din_vd(din_vd0), .rd_en(rd_en0), .err_clr(err_clr0),
      .dout(dout0), .dout_vd(dout_vd0), .full(full0), .almost_full(almost_full0), .empty(empty0),
      .almost_empty(almost_empty0), .burst_rdy(burst_rdy0), .data_cnt(data_cnt0),
      .overflow(overflow0), .underflow(underflow0)
   );

   rd_data_fifo_sc #(
      .DATA_WIDTH(128), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .BURST_LEN(8), .AUTO_DRAIN(1)
   ) dut1 (
      .clk(clk), .reset(reset), .din(din1), .din_vd(din_vd1), .rd_en(rd_en1), .err_clr(err_clr1),
      .dout(dout1), .dout_vd(dout_vd1), .full(full1), .almost_full(almost_full1), .empty(empty1),
      .almost_empty(almost_empty1), .burst_rdy(burst_rdy1), .data_cnt(data_cnt1),
      .overflow(overflow1), .underflow(underflow1)
   );

   always #5 clk = ~clk;

   task automatic check1(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour: a word queue plus sticky error bits, evaluated on pre-edge occupancy.
   task automatic modelStep(input int i, input bit auto_m, input bit rst, input logic [127:0] d,
                            input bit wr, input bit rd, input bit clr, inout wq_t q);
      bit was_full, was_empty, req;
      if (rst) begin
         q.delete();
         m_dout[i] = '0;
         m_vd[i]   = 1'b0;
         m_ov[i]   = 1'b0;
         m_un[i]   = 1'b0;
         return;
      end
      was_full  = (q.size() == 16);
      was_empty = (q.size() == 0);
      req       = auto_m ? !was_empty : rd;
      if (req && !was_empty) begin
         m_dout[i] = q.pop_front();
         m_vd[i]   = 1'b1;
      end else begin
         m_vd[i]   = 1'b0;
      end
      if (wr && !was_full) q.push_back(d);
      if (wr && was_full) m_ov[i] = 1'b1;
      else if (clr)       m_ov[i] = 1'b0;
      if (!auto_m && rd && was_empty) m_un[i] = 1'b1;
      else if (clr)                   m_un[i] = 1'b0;
   endtask

   task automatic checkOutput(input int i, input int n, input logic [127:0] dout, input logic vd,
                              input logic full, input logic af, input logic empty, input logic ae,
                              input logic burst, input logic [4:0] cnt, input logic ov, input logic un);
      string p;
      p = (i == 0) ? "m0" : "m1";
      check1({p, "_cnt"},   128'(cnt),   128'(n));
      check1({p, "_full"},  128'(full),  128'(n == 16));
      check1({p, "_af"},    128'(af),    128'(n >= 12));
      check1({p, "_empty"}, 128'(empty), 128'(n == 0));
      check1({p, "_ae"},    128'(ae),    128'(n <= 2));
      check1({p, "_burst"}, 128'(burst), 128'(n >= 8));
      check1({p, "_vd"},    128'(vd),    128'(m_vd[i]));
      check1({p, "_dout"},  dout,        m_dout[i]);
      check1({p, "_ovf"},   128'(ov),    128'(m_ov[i]));
      check1({p, "_unf"},   128'(un),    128'(m_un[i]));
   endtask

   // One clock: advance the model with the current inputs, clock the DUTs, compare both.
   task automatic applyStimulus();
      modelStep(0, 1'b0, reset, din0, din_vd0, rd_en0, err_clr0, q0);
      modelStep(1, 1'b1, reset, din1, din_vd1, rd_en1, err_clr1, q1);
      @(posedge clk);
      #1;
      checkOutput(0, q0.size(), dout0, dout_vd0, full0, almost_full0, empty0, almost_empty0,
                  burst_rdy0, data_cnt0, overflow0, underflow0);
      checkOutput(1, q1.size(), dout1, dout_vd1, full1, almost_full1, empty1, almost_empty1,
                  burst_rdy1, data_cnt1, overflow1, underflow1);
   endtask

   task automatic setIdle();
      reset = 1'b0;
      din_vd0 = 1'b0; rd_en0 = 1'b0; err_clr0 = 1'b0; din0 = '0;
      din_vd1 = 1'b0; rd_en1 = 1'b0; err_clr1 = 1'b0; din1 = '0;
   endtask

   function automatic vec_t mk(input bit rst, input bit wr, input bit rd, input bit clr,
                               input logic [127:0] d, input int cnt, input bit vd,
                               input logic [127:0] dq, input bit ov, input bit un);
      vec_t v;
      v.rst = rst; v.wr = wr; v.rd = rd; v.clr = clr; v.din = d;
      v.cnt = cnt; v.vd = vd; v.dout = dq; v.ov = ov; v.un = un;
      return v;
   endfunction

   initial begin
      logic [127:0] got [$];
      int           first_vd;
      logic [127:0] exp_word;

      // Directed table on the rd_en-driven instance: fill, overflow, drain, underflow, clears.
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < 16; k++) vecs.push_back(mk(0, 1, 0, 0, 128'(k), k + 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 128'd99, 16, 0, 0, 1, 0));
      vecs.push_back(mk(0, 1, 1, 0, 128'd77, 15, 1, 0, 1, 0));
      for (int k = 1; k < 16; k++) vecs.push_back(mk(0, 0, 1, 0, 0, 15 - k, 1, 128'(k), 1, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 128'd15, 1, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 128'd15, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 128'd55, 1, 0, 128'd15, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 128'd15, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 128'd55, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 128'd55, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 128'd55, 0, 0));

      setIdle();
      for (int i = 0; i < vecs.size(); i++) begin
         reset = vecs[i].rst; din0 = vecs[i].din; din_vd0 = vecs[i].wr;
         rd_en0 = vecs[i].rd; err_clr0 = vecs[i].clr;
         applyStimulus();
         check1("tbl_cnt",   128'(data_cnt0),     128'(vecs[i].cnt));
         check1("tbl_full",  128'(full0),         128'(vecs[i].cnt == 16));
         check1("tbl_af",    128'(almost_full0),  128'(vecs[i].cnt >= 12));
         check1("tbl_empty", 128'(empty0),        128'(vecs[i].cnt == 0));
         check1("tbl_ae",    128'(almost_empty0), 128'(vecs[i].cnt <= 2));
         check1("tbl_burst", 128'(burst_rdy0),    128'(vecs[i].cnt >= 8));
         check1("tbl_vd",    128'(dout_vd0),      128'(vecs[i].vd));
         check1("tbl_dout",  dout0,               vecs[i].dout);
         check1("tbl_ovf",   128'(overflow0),     128'(vecs[i].ov));
         check1("tbl_unf",   128'(underflow0),    128'(vecs[i].un));
      end

      // Pointer wrap: hold occupancy at 5 with simultaneous write and read.
      setIdle(); reset = 1'b1; applyStimulus(); reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         din_vd0 = 1'b1; din0 = 128'(200 + k); applyStimulus();
      end
      for (int k = 0; k < 24; k++) begin
         din_vd0 = 1'b1; rd_en0 = 1'b1; din0 = 128'(300 + k);
         applyStimulus();
         exp_word = (k < 5) ? 128'(200 + k) : 128'(300 + k - 5);
         check1("wrap_cnt",  128'(data_cnt0),     128'd5);
         check1("wrap_ae",   128'(almost_empty0), 128'd0);
         check1("wrap_vd",   128'(dout_vd0),      128'd1);
         check1("wrap_dout", dout0,               exp_word);
      end

      // Reset with data present and a concurrent write.
      setIdle(); reset = 1'b1; applyStimulus(); reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         din_vd0 = 1'b1; din0 = 128'(k); applyStimulus();
      end
      check1("pre_rst_cnt", 128'(data_cnt0), 128'd10);
      reset = 1'b1; din_vd0 = 1'b1; din0 = 128'hDEAD;
      applyStimulus();
      check1("rst_cnt",   128'(data_cnt0), 128'd0);
      check1("rst_empty", 128'(empty0),    128'd1);
      check1("rst_vd",    128'(dout_vd0),  128'd0);
      setIdle(); applyStimulus();
      check1("rst_discard", 128'(data_cnt0), 128'd0);

      // Auto-drain burst with rd_en held high (it must be ignored).
      setIdle(); reset = 1'b1; applyStimulus(); reset = 1'b0;
      first_vd = -1;
      for (int t = 1; t <= 12; t++) begin
         din_vd1 = (t <= 8); din1 = 128'(8'hA0 + t - 1); rd_en1 = 1'b1;
         applyStimulus();
         if (dout_vd1) begin
            if (first_vd < 0) first_vd = t;
            got.push_back(dout1);
         end
         check1("ad_unf", 128'(underflow1), 128'd0);
      end
      check1("ad_first_vd", 128'(first_vd), 128'd2);
      check1("ad_count",    128'(got.size()), 128'd8);
      for (int k = 0; k < got.size(); k++) check1("ad_word", got[k], 128'(8'hA0 + k));
      check1("ad_empty", 128'(empty1), 128'd1);

      // Random traffic on both instances against the model, alternating fill- and drain-biased phases.
      setIdle();
      for (int c = 0; c < 3000; c++) begin
         int wp;
         wp       = ((c / 300) % 2 == 1) ? 75 : 30;
         reset    = ($urandom_range(0, 299) == 0);
         din0     = {$urandom, $urandom, $urandom, $urandom};
         din1     = {$urandom, $urandom, $urandom, $urandom};
         din_vd0  = ($urandom_range(0, 99) < wp);
         din_vd1  = ($urandom_range(0, 99) < wp);
         rd_en0   = ($urandom_range(0, 99) < 50);
         rd_en1   = ($urandom_range(0, 99) < 50);
         err_clr0 = ($urandom_range(0, 19) == 0);
         err_clr1 = ($urandom_range(0, 19) == 0);
         applyStimulus();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
